// File: rtl/hp_pkg.sv
// Shared binary16 definitions: field widths, canonical encodings, class flags,
// the divider state enum and its debug view.
package hp_pkg;

  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int SIG_W    = 11;
  localparam int BIAS     = 15;
  localparam int EMIN     = -14;
  localparam int EMIN_SUB = -24;
  localparam int EMAX     = 15;

  localparam logic [15:0] POS_INF  = 16'h7C00;
  localparam logic [15:0] NEG_INF  = 16'hFC00;
  localparam logic [15:0] POS_ZERO = 16'h0000;
  localparam logic [15:0] NEG_ZERO = 16'h8000;

  typedef struct packed {
    logic snan;
    logic qnan;
    logic infinity;
    logic zero;
    logic subnormal;
    logic normal;
  } hp_cls_t;

  localparam hp_cls_t CLS_NONE = 6'b000000;
  localparam hp_cls_t CLS_SNAN = 6'b100000;
  localparam hp_cls_t CLS_QNAN = 6'b010000;
  localparam hp_cls_t CLS_INF  = 6'b001000;
  localparam hp_cls_t CLS_ZERO = 6'b000100;
  localparam hp_cls_t CLS_SUB  = 6'b000010;
  localparam hp_cls_t CLS_NORM = 6'b000001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLASS = 3'd1,
    NORM  = 3'd2,
    DIV   = 3'd3,
    PACK  = 3'd4,
    DONE  = 3'd5
  } hp_state_t;

  typedef struct packed {
    hp_state_t state;
    logic      inexact;
  } hp_dbg_t;

  function automatic logic [15:0] hp_gen_qnan(input logic sign, input logic [8:0] payload);
    return {sign, 5'h1F, 1'b1, payload};
  endfunction

endpackage

// File: rtl/hp_div_if.sv
// Operand/result bundle of the half-precision divider, with a debug view of
// the FSM state.
interface hp_div_if;
  import hp_pkg::*;

  // i_start is a request sampled only while o_busy=0 and not in the o_done
  // cycle; o_done pulses for one cycle and o_q/flags hold until the next pulse.
  logic        i_start;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_q;
  logic        o_snan;
  logic        o_qnan;
  logic        o_infinity;
  logic        o_zero;
  logic        o_subnormal;
  logic        o_normal;
  hp_dbg_t     o_dbg;

  modport slave (
    input  i_start, i_a, i_b,
    output o_busy, o_done, o_q, o_snan, o_qnan, o_infinity, o_zero,
           o_subnormal, o_normal, o_dbg
  );

  modport master (
    output i_start, i_a, i_b,
    input  o_busy, o_done, o_q, o_snan, o_qnan, o_infinity, o_zero,
           o_subnormal, o_normal, o_dbg
  );
endinterface

// File: rtl/hp_class.sv
// Binary16 operand classifier: exactly one of the six class flags is set.
module hp_class
  import hp_pkg::*;
(
  input  logic [15:0] i_x,
  output hp_cls_t     o_cls
);
  logic [4:0] w_exp;
  logic [9:0] w_frac;

  assign w_exp  = i_x[14:10];
  assign w_frac = i_x[9:0];

  always_comb begin
    o_cls = CLS_NONE;
    if (w_exp == 5'h1F) begin
      if (w_frac == 10'h000)  o_cls = CLS_INF;
      else if (w_frac[9])     o_cls = CLS_QNAN;
      else                    o_cls = CLS_SNAN;
    end else if (w_exp == 5'h00) begin
      if (w_frac == 10'h000)  o_cls = CLS_ZERO;
      else                    o_cls = CLS_SUB;
    end else begin
      o_cls = CLS_NORM;
    end
  end
endmodule

// File: rtl/hp_lzc11.sv
// 11-bit leading-zero counter; an all-zero input reports 11.
module hp_lzc11 (
  input  logic [10:0] i_x,
  output logic [3:0]  o_cnt
);
  always_comb begin
    o_cnt = 4'd11;
    // Scanning upward lets the highest set bit have the final say.
    for (int i = 0; i <= 10; i++) begin
      if (i_x[i]) o_cnt = 4'(10 - i);
    end
  end
endmodule

// File: rtl/hp_div.sv
// Iterative binary16 divider q = a / b, one quotient bit per clock.
// Define HP_DIV_RNE_EN for round-to-nearest-even on normal results; default truncates.
module hp_div
  import hp_pkg::*;
#(
  parameter logic [8:0] QNAN_PAYLOAD = 9'h2A
) (
  input  logic    i_clk,
  input  logic    i_rst,
  hp_div_if.slave bus
);
  localparam logic signed [6:0] L_BIAS     = 7'(BIAS);
  localparam logic signed [6:0] L_EMIN     = 7'(EMIN);
  localparam logic signed [6:0] L_EMIN_SUB = 7'(EMIN_SUB);
  localparam logic signed [6:0] L_EMAX     = 7'(EMAX);

  hp_state_t         r_state;
  logic [15:0]       r_a, r_b;
  logic              r_sign, r_special, r_busy, r_done, r_inexact;
  logic [15:0]       r_res_q, r_q;
  hp_cls_t           r_res_cls, r_cls;
  logic signed [6:0] r_e;
  logic [11:0]       r_rem;
  logic [10:0]       r_div;
  logic [12:0]       r_quo;
  logic [3:0]        r_cnt;

  hp_cls_t w_cls_a, w_cls_b;
  hp_class u_cls_a (.i_x(r_a), .o_cls(w_cls_a));
  hp_class u_cls_b (.i_x(r_b), .o_cls(w_cls_b));

  logic w_sign;
  assign w_sign = r_a[15] ^ r_b[15];

  // Normalisation: subnormals get their leading one moved to bit 10.
  logic [10:0]       w_sig_a, w_sig_b, w_sig_an, w_sig_bn;
  logic [3:0]        w_lzc_a, w_lzc_b;
  logic signed [6:0] w_exp_a, w_exp_b;

  assign w_sig_a = {w_cls_a.normal, r_a[9:0]};
  assign w_sig_b = {w_cls_b.normal, r_b[9:0]};

  hp_lzc11 u_lzc_a (.i_x(w_sig_a), .o_cnt(w_lzc_a));
  hp_lzc11 u_lzc_b (.i_x(w_sig_b), .o_cnt(w_lzc_b));

  assign w_sig_an = 11'(w_sig_a << w_lzc_a);
  assign w_sig_bn = 11'(w_sig_b << w_lzc_b);
  assign w_exp_a  = (w_cls_a.subnormal ? L_EMIN : ($signed({2'b00, r_a[14:10]}) - L_BIAS))
                    - $signed({3'b000, w_lzc_a});
  assign w_exp_b  = (w_cls_b.subnormal ? L_EMIN : ($signed({2'b00, r_b[14:10]}) - L_BIAS))
                    - $signed({3'b000, w_lzc_b});

  logic        w_spec;
  logic [15:0] w_spec_q;
  hp_cls_t     w_spec_cls;

  always_comb begin
    w_spec     = 1'b1;
    w_spec_q   = r_a;
    w_spec_cls = CLS_SNAN;
    if (w_cls_a.snan) begin
      w_spec_q = r_a;
    end else if (w_cls_b.snan) begin
      w_spec_q = r_b;
    end else if (w_cls_a.qnan) begin
      w_spec_q   = r_a;
      w_spec_cls = CLS_QNAN;
    end else if (w_cls_b.qnan) begin
      w_spec_q   = r_b;
      w_spec_cls = CLS_QNAN;
    end else if ((w_cls_a.infinity && w_cls_b.infinity) || (w_cls_a.zero && w_cls_b.zero)) begin
      w_spec_q   = hp_gen_qnan(w_sign, QNAN_PAYLOAD);
      w_spec_cls = CLS_QNAN;
    end else if (w_cls_a.infinity || w_cls_b.zero) begin
      w_spec_q   = w_sign ? NEG_INF : POS_INF;
      w_spec_cls = CLS_INF;
    end else if (w_cls_b.infinity || w_cls_a.zero) begin
      w_spec_q   = w_sign ? NEG_ZERO : POS_ZERO;
      w_spec_cls = CLS_ZERO;
    end else begin
      w_spec     = 1'b0;
      w_spec_q   = 16'h0000;
      w_spec_cls = CLS_NONE;
    end
  end

  // Restoring division step.
  logic        w_ge;
  logic [11:0] w_diff, w_rem_nx;
  assign w_ge     = r_rem >= {1'b0, r_div};
  assign w_diff   = r_rem - {1'b0, r_div};
  assign w_rem_nx = w_ge ? w_diff : r_rem;

  logic              w_int, w_guard, w_sticky, w_inexact;
  logic [10:0]       w_sig;
  logic signed [6:0] w_ep, w_sh, w_e_r;
  logic [9:0]        w_frac_r;

  assign w_int     = r_quo[12];
  assign w_sig     = w_int ? r_quo[12:2] : r_quo[11:1];
  assign w_guard   = w_int ? r_quo[1] : r_quo[0];
  assign w_sticky  = |r_rem;
  assign w_inexact = w_guard | w_sticky;
  assign w_ep      = w_int ? r_e : r_e - 7'sd1;
  assign w_sh      = L_EMIN - w_ep;

`ifdef HP_DIV_RNE_EN
  logic        w_up;
  logic [11:0] w_sig_r;
  assign w_up     = w_guard & (w_sticky | w_sig[0]);
  assign w_sig_r  = {1'b0, w_sig} + {11'b0, w_up};
  // A carry out of the significand renormalises to 1.0 in the next binade.
  assign w_e_r    = w_sig_r[11] ? w_ep + 7'sd1 : w_ep;
  assign w_frac_r = w_sig_r[11] ? 10'h000 : 10'(w_sig_r);
`else
  assign w_e_r    = w_ep;
  assign w_frac_r = 10'(w_sig);
`endif

  logic [15:0] w_pack_q;
  hp_cls_t     w_pack_cls;

  always_comb begin
    w_pack_q   = {r_sign, 15'h0000};
    w_pack_cls = CLS_ZERO;
    if (w_ep < L_EMIN_SUB) begin
      w_pack_q   = {r_sign, 15'h0000};
      w_pack_cls = CLS_ZERO;
    end else if (w_ep < L_EMIN) begin
      w_pack_q   = {r_sign, 5'h00, 10'(w_sig >> w_sh)};
      w_pack_cls = CLS_SUB;
    end else if (w_e_r > L_EMAX) begin
      w_pack_q   = r_sign ? NEG_INF : POS_INF;
      w_pack_cls = CLS_INF;
    end else begin
      w_pack_q   = {r_sign, 5'(w_e_r + L_BIAS), w_frac_r};
      w_pack_cls = CLS_NORM;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sign    <= 1'b0;
      r_special <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_inexact <= 1'b0;
      r_res_q   <= '0;
      r_res_cls <= CLS_NONE;
      r_q       <= '0;
      r_cls     <= CLS_NONE;
      r_e       <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_b;
            r_busy  <= 1'b1;
            r_state <= CLASS;
          end
        end
        CLASS: begin
          // Specials skip the datapath but still publish through PACK.
          r_sign    <= w_sign;
          r_special <= w_spec;
          r_res_q   <= w_spec_q;
          r_res_cls <= w_spec_cls;
          r_state   <= w_spec ? PACK : NORM;
        end
        NORM: begin
          r_e     <= w_exp_a - w_exp_b;
          r_rem   <= {1'b0, w_sig_an};
          r_div   <= w_sig_bn;
          r_quo   <= '0;
          r_cnt   <= 4'd12;
          r_state <= DIV;
        end
        DIV: begin
          r_rem <= 12'(w_rem_nx << 1);
          r_quo <= {r_quo[11:0], w_ge};
          if (r_cnt == 4'd0) r_state <= PACK;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        PACK: begin
          r_q       <= r_special ? r_res_q   : w_pack_q;
          r_cls     <= r_special ? r_res_cls : w_pack_cls;
          r_inexact <= ~r_special & w_inexact;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_q         = r_q;
  assign bus.o_snan      = r_cls.snan;
  assign bus.o_qnan      = r_cls.qnan;
  assign bus.o_infinity  = r_cls.infinity;
  assign bus.o_zero      = r_cls.zero;
  assign bus.o_subnormal = r_cls.subnormal;
  assign bus.o_normal    = r_cls.normal;
  assign bus.o_dbg       = '{state: r_state, inexact: r_inexact};

endmodule

// File: tb/tb_hp_div.sv
// Scoreboard bench for hp_div: directed table, randomized operands against an
// integer-arithmetic reference, back-to-back issue, busy-time noise and reset abort.
module tb_hp_div;
  import hp_pkg::*;

  localparam int W = 22;
  localparam logic [5:0] F_SNAN = 6'b100000;
  localparam logic [5:0] F_QNAN = 6'b010000;
  localparam logic [5:0] F_INF  = 6'b001000;
  localparam logic [5:0] F_ZERO = 6'b000100;
  localparam logic [5:0] F_SUB  = 6'b000010;
  localparam logic [5:0] F_NORM = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hp_div_if bus ();
  hp_div dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int unsigned  cap_q[$];
  int unsigned  lat_q[$];
  bit           b2b_chk   = 1'b0;
  bit           have_last = 1'b0;
  int unsigned  last_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [5:0] flags_now();
    return {bus.o_snan, bus.o_qnan, bus.o_infinity, bus.o_zero, bus.o_subnormal, bus.o_normal};
  endfunction

  function automatic bit is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
  endfunction
  function automatic bit is_snan(input logic [15:0] x);
    return is_nan(x) && !x[9];
  endfunction
  function automatic bit is_qnan(input logic [15:0] x);
    return is_nan(x) && x[9];
  endfunction
  function automatic bit is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'h0);
  endfunction
  function automatic bit is_zero(input logic [15:0] x);
    return x[14:0] == 15'h0;
  endfunction

  // Value = m * 2^(e-10) with m in [1024, 2047].
  task automatic decode(input logic [15:0] x, output int m, output int e);
    if (x[14:10] == 5'h0) begin
      m = int'(x[9:0]);
      e = -14;
    end else begin
      m = 1024 + int'(x[9:0]);
      e = int'(x[14:10]) - 15;
    end
    while (m < 1024) begin
      m = m * 2;
      e = e - 1;
    end
  endtask

  task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [W-1:0] res, output int unsigned lat);
    logic        s;
    logic [15:0] q;
    int          ma, ea, mb, eb, num, quo, e, sig;
`ifdef HP_DIV_RNE_EN
    int          g;
    bit          st;
`endif
    s   = a[15] ^ b[15];
    lat = 2;
    if (is_snan(a))                                        res = {a, F_SNAN};
    else if (is_snan(b))                                   res = {b, F_SNAN};
    else if (is_qnan(a))                                   res = {a, F_QNAN};
    else if (is_qnan(b))                                   res = {b, F_QNAN};
    else if ((is_inf(a) && is_inf(b)) || (is_zero(a) && is_zero(b)))
                                                           res = {s, 5'h1F, 1'b1, 9'h2A, F_QNAN};
    else if (is_inf(a) || is_zero(b))                      res = {s, 15'h7C00, F_INF};
    else if (is_inf(b) || is_zero(a))                      res = {s, 15'h0000, F_ZERO};
    else begin
      lat = 16;
      decode(a, ma, ea);
      decode(b, mb, eb);
      num = ma * 4096;
      quo = num / mb;
      e   = ea - eb;
`ifdef HP_DIV_RNE_EN
      st = (num % mb) != 0;
`endif
      if (quo >= 4096) begin
        sig = quo / 4;
`ifdef HP_DIV_RNE_EN
        g = (quo / 2) % 2;
`endif
      end else begin
        sig = (quo / 2) % 2048;
`ifdef HP_DIV_RNE_EN
        g = quo % 2;
`endif
        e = e - 1;
      end
      if (e < -24) begin
        res = {s, 15'h0000, F_ZERO};
      end else if (e < -14) begin
        sig = sig >> (-14 - e);
        q   = {s, 5'h00, sig[9:0]};
        res = {q, F_SUB};
      end else begin
`ifdef HP_DIV_RNE_EN
        if (g == 1 && (st || (sig % 2) == 1)) sig = sig + 1;
        if (sig == 2048) begin
          sig = 1024;
          e   = e + 1;
        end
`endif
        if (e > 15) res = {s, 15'h7C00, F_INF};
        else begin
          q   = {s, 5'(e + 15), sig[9:0]};
          res = {q, F_NORM};
        end
      end
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    int unsigned  c, l;
    if (!rst && bus.o_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got q=%h with no request outstanding (cycle %0d)", bus.o_q, cyc);
      end else begin
        e = exp_q.pop_front();
        c = cap_q.pop_front();
        l = lat_q.pop_front();
        chk("q", 32'(bus.o_q), 32'(e[21:6]));
        chk("flags", 32'(flags_now()), 32'(e[5:0]));
        chk("latency", cyc - c, l);
        chk("busy_at_done", 32'(bus.o_busy), 32'd0);
        if (b2b_chk && have_last) chk("b2b_spacing", cyc - last_done, 32'd18);
        last_done = cyc;
        have_last = 1'b1;
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [W-1:0] e,
                       input int unsigned lat, input bit hold, input bit garbage,
                       output int unsigned cap);
    int t;
    cap = 0;
    t   = 0;
    @(negedge clk);
    while (!(bus.o_busy === 1'b0 && bus.o_done === 1'b0)) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        n_vec++;
        n_err++;
        $display("FAIL idle_timeout: got busy=%b done=%b expected idle", bus.o_busy, bus.o_done);
        return;
      end
    end
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    cap = cyc;
    exp_q.push_back(e);
    cap_q.push_back(cap);
    lat_q.push_back(lat);
    if (!hold) bus.i_start = 1'b0;
    if (garbage) begin
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (bus.o_busy === 1'b1 || bus.o_done === 1'b1) begin
          bus.i_start = 1'b1;
          bus.i_a     = 16'($urandom);
          bus.i_b     = 16'($urandom);
        end else begin
          bus.i_start = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
      cap_q.delete();
      lat_q.delete();
    end
  endtask

  function automatic logic [15:0] rand_operand();
    logic [15:0] x;
    logic [15:0] sp[8];
    sp = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7C01, 16'hFE15, 16'h7D00};
    x  = 16'($urandom);
    case ($urandom_range(0, 4))
      0:       x = x;
      1, 2:    x[14:10] = 5'($urandom_range(1, 30));
      3:       x[14:10] = 5'h00;
      default: x = sp[$urandom_range(0, 7)];
    endcase
    return x;
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [5:0]  f;
    int unsigned lat;
  } vec_t;

  initial begin
    vec_t         dir[11];
    logic [W-1:0] e;
    logic [15:0]  a, b;
    int unsigned  lat, cap;

    bus.i_start = 1'b0;
    bus.i_a     = 16'h0;
    bus.i_b     = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q", 32'(bus.o_q), 32'h0);
    chk("rst_flags", 32'(flags_now()), 32'h0);
    chk("rst_busy", 32'(bus.o_busy), 32'h0);
    chk("rst_done", 32'(bus.o_done), 32'h0);
    rst = 1'b0;

`ifdef HP_DIV_RNE_EN
    dir[0] = '{16'h4500, 16'h4200, 16'h3EAB, F_NORM, 16};
`else
    dir[0] = '{16'h4500, 16'h4200, 16'h3EAA, F_NORM, 16};
`endif
    dir[1]  = '{16'h3C00, 16'h4000, 16'h3800, F_NORM, 16};
    dir[2]  = '{16'hC200, 16'h4000, 16'hBE00, F_NORM, 16};
    dir[3]  = '{16'h0001, 16'h0001, 16'h3C00, F_NORM, 16};
    dir[4]  = '{16'h0400, 16'h4000, 16'h0200, F_SUB,  16};
    dir[5]  = '{16'h7BFF, 16'h3800, 16'h7C00, F_INF,  16};
    dir[6]  = '{16'h0001, 16'h7BFF, 16'h0000, F_ZERO, 16};
    dir[7]  = '{16'h0000, 16'h0000, 16'h7E2A, F_QNAN, 2};
    dir[8]  = '{16'h3C00, 16'h8000, 16'hFC00, F_INF,  2};
    dir[9]  = '{16'h7C01, 16'h7E00, 16'h7C01, F_SNAN, 2};
    dir[10] = '{16'h3C00, 16'h7C00, 16'h0000, F_ZERO, 2};
    for (int i = 0; i < 11; i++) begin
      issue(dir[i].a, dir[i].b, {dir[i].q, dir[i].f}, dir[i].lat, 1'b0, (i % 2) == 1, cap);
      drain();
    end

    // Randomized operands, some with noise on the inputs while busy.
    for (int i = 0; i < 250; i++) begin
      a = rand_operand();
      b = rand_operand();
      ref_div(a, b, e, lat);
      issue(a, b, e, lat, 1'b0, $urandom_range(0, 3) == 0, cap);
    end
    drain();

    // Start held high: captures resume as soon as the block returns to idle.
    have_last = 1'b0;
    b2b_chk   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = {1'b0, 5'($urandom_range(5, 25)), 10'($urandom)};
      b = {1'b1, 5'($urandom_range(5, 25)), 10'($urandom)};
      ref_div(a, b, e, lat);
      issue(a, b, e, lat, 1'b1, 1'b0, cap);
    end
    @(negedge clk);
    bus.i_start = 1'b0;
    drain();
    b2b_chk = 1'b0;

    // Reset in the middle of DIV abandons the operation silently.
    ref_div(16'h4500, 16'h4200, e, lat);
    issue(16'h4500, 16'h4200, e, lat, 1'b0, 1'b0, cap);
    while (cyc < cap + 9) @(negedge clk);
    chk("pre_rst_state", 32'(bus.o_dbg.state), 32'(DIV));
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(cap_q.pop_back());
    void'(lat_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.o_busy), 32'h0);
    chk("abort_done", 32'(bus.o_done), 32'h0);
    chk("abort_q", 32'(bus.o_q), 32'h0);
    chk("abort_flags", 32'(flags_now()), 32'h0);
    chk("abort_state", 32'(bus.o_dbg.state), 32'(IDLE));
    repeat (25) @(negedge clk);
    ref_div(16'hC200, 16'h4000, e, lat);
    issue(16'hC200, 16'h4000, e, lat, 1'b0, 1'b0, cap);
    drain();

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
